// File: rtl/block_memory_responder.sv
// +----------------------------------------------------------------------------+
// | block_memory_responder                                                     |
// | Backing-memory slave: one block read/write at a time, fixed-latency reply. |
// | Optional feature macro: BLOCK_MEMORY_RESP_ERR_EN (out-of-range responses). |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module block_memory_responder #(
  parameter int ADDR_SIZE  = 32,
  parameter int BLOCK_SIZE = 32,
  parameter int MEM_DEPTH  = 1024,
  parameter int LATENCY    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_SIZE-1:0]  req_addr,
  input  logic                  req_write,
  input  logic [BLOCK_SIZE-1:0] req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [BLOCK_SIZE-1:0] resp_rdata,
  output logic                  busy
`ifdef BLOCK_MEMORY_RESP_ERR_EN
  ,
  output logic                  resp_err
`endif
);

  localparam int OFS = $clog2(BLOCK_SIZE / 8);
  localparam int IDX = $clog2(MEM_DEPTH);
  localparam int CW  = $clog2(LATENCY + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t                state, state_next;
  logic [CW-1:0]         cnt, cnt_next;
  logic                  load_resp;
  logic                  accept;

  logic [IDX-1:0]        req_idx;
  logic                  req_oor;
  logic [IDX-1:0]        idx_q;
  logic                  write_q;
  logic                  oor_q;
  logic [BLOCK_SIZE-1:0] wdata_q;

  logic [IDX-1:0]        src_idx;
  logic                  src_write;
  logic                  src_oor;
  logic [BLOCK_SIZE-1:0] src_wdata;

  logic [BLOCK_SIZE-1:0] mem [MEM_DEPTH];

  logic                  unused_addr;

  assign req_idx     = req_addr[OFS +: IDX];
  assign unused_addr = ^req_addr;

`ifdef BLOCK_MEMORY_RESP_ERR_EN
  // Any address bit above the array's reach marks the request out of range.
  if (ADDR_SIZE > OFS + IDX) begin : g_oor_check
    assign req_oor = |req_addr[ADDR_SIZE-1:OFS+IDX];
  end else begin : g_oor_none
    assign req_oor = 1'b0;
  end
  assign resp_err = resp_valid & oor_q;
`else
  assign req_oor = 1'b0;
`endif

  assign accept = (state == S_IDLE) && req_valid && rst;

  // With LATENCY==1 the response is loaded straight from the live request.
  assign src_idx   = (state == S_IDLE) ? req_idx   : idx_q;
  assign src_write = (state == S_IDLE) ? req_write : write_q;
  assign src_oor   = (state == S_IDLE) ? req_oor   : oor_q;
  assign src_wdata = (state == S_IDLE) ? req_wdata : wdata_q;

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    load_resp  = 1'b0;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    busy       = 1'b1;
    case (state)
      S_IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
        if (req_valid) begin
          cnt_next = '0;
          if (LATENCY > 1) begin
            state_next = S_WAIT;
          end else begin
            state_next = S_RESP;
            load_resp  = 1'b1;
          end
        end
      end
      S_WAIT: begin
        cnt_next = cnt + CW'(1);
        if (cnt_next == CNT_LAST) begin
          state_next = S_RESP;
          load_resp  = 1'b1;
        end
      end
      S_RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) begin
          state_next = S_IDLE;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      idx_q      <= '0;
      write_q    <= 1'b0;
      oor_q      <= 1'b0;
      wdata_q    <= '0;
      resp_rdata <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (accept) begin
        idx_q   <= req_idx;
        write_q <= req_write;
        oor_q   <= req_oor;
        wdata_q <= req_wdata;
      end
      if (load_resp) begin
        if (src_oor) begin
          resp_rdata <= '0;
        end else if (src_write) begin
          resp_rdata <= src_wdata;
        end else begin
          resp_rdata <= mem[src_idx];
        end
      end
    end
  end

  // Contents are never reset; a write lands at acceptance and survives aborts.
  always_ff @(posedge clk) begin
    if (accept && req_write && !req_oor) begin
      mem[req_idx] <= req_wdata;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_block_memory_responder.sv
// +----------------------------------------------------------------------------+
// | tb_block_memory_responder                                                  |
// | Directed, table-driven bench for block_memory_responder (LATENCY 4 and 1). |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_block_memory_responder;

  localparam int LAT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_write, resp_ready;
  logic [31:0] req_addr, req_wdata;
  logic        req_ready, resp_valid, busy;
  logic [31:0] resp_rdata;

  logic        req_valid_1, req_write_1, resp_ready_1;
  logic [31:0] req_addr_1, req_wdata_1;
  logic        req_ready_1, resp_valid_1, busy_1;
  logic [31:0] resp_rdata_1;

`ifdef BLOCK_MEMORY_RESP_ERR_EN
  logic        resp_err, resp_err_1;
`endif

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  block_memory_responder #(
    .ADDR_SIZE(32), .BLOCK_SIZE(32), .MEM_DEPTH(1024), .LATENCY(LAT)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_write(req_write), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .busy(busy)
`ifdef BLOCK_MEMORY_RESP_ERR_EN
    , .resp_err(resp_err)
`endif
  );

  block_memory_responder #(
    .ADDR_SIZE(32), .BLOCK_SIZE(32), .MEM_DEPTH(1024), .LATENCY(1)
  ) dut1 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid_1), .req_ready(req_ready_1), .req_addr(req_addr_1),
    .req_write(req_write_1), .req_wdata(req_wdata_1),
    .resp_valid(resp_valid_1), .resp_ready(resp_ready_1), .resp_rdata(resp_rdata_1),
    .busy(busy_1)
`ifdef BLOCK_MEMORY_RESP_ERR_EN
    , .resp_err(resp_err_1)
`endif
  );

  typedef struct {
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          hold;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) begin
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end else begin
      pass_cnt++;
    end
  endtask

  task automatic run_txn(input vec_t v, input string tag);
    int   lat;
    logic stable;
    req_addr  = v.addr;
    req_write = v.write;
    req_wdata = v.wdata;
    req_valid = 1'b1;
    check({tag, " req_ready_before"}, {31'd0, req_ready}, 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    check({tag, " busy_after_accept"}, {31'd0, busy}, 32'd1);
    lat = 1;
    while (!resp_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, " latency"}, 32'(lat), 32'(LAT));
    check({tag, " rdata"}, resp_rdata, v.exp_rdata);
`ifdef BLOCK_MEMORY_RESP_ERR_EN
    check({tag, " resp_err"}, {31'd0, resp_err}, {31'd0, v.exp_err});
`endif
    stable = 1'b1;
    repeat (v.hold) begin
      @(posedge clk); #1;
      if (!resp_valid || resp_rdata !== v.exp_rdata) stable = 1'b0;
    end
    if (v.hold > 0) check({tag, " held_stable"}, {31'd0, stable}, 32'd1);
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    check({tag, " req_ready_after"}, {31'd0, req_ready}, 32'd1);
    check({tag, " resp_valid_after"}, {31'd0, resp_valid}, 32'd0);
  endtask

  task automatic run_txn1(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                          input logic [31:0] exp, input string tag);
    req_addr_1  = addr;
    req_write_1 = wr;
    req_wdata_1 = wdata;
    req_valid_1 = 1'b1;
    @(posedge clk); #1;
    req_valid_1 = 1'b0;
    check({tag, " resp_valid_next_cycle"}, {31'd0, resp_valid_1}, 32'd1);
    check({tag, " rdata"}, resp_rdata_1, exp);
    resp_ready_1 = 1'b1;
    @(posedge clk); #1;
    resp_ready_1 = 1'b0;
    check({tag, " req_ready_after"}, {31'd0, req_ready_1}, 32'd1);
  endtask

  initial begin
    logic quiet;
    rst = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; resp_ready = 1'b0;
    req_valid_1 = 1'b0; req_write_1 = 1'b0; req_addr_1 = '0; req_wdata_1 = '0; resp_ready_1 = 1'b0;

    vecs[0] = '{32'h0000_0040, 1'b1, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 0};
    vecs[1] = '{32'h0000_0040, 1'b0, 32'h0,         32'hDEAD_BEEF, 1'b0, 0};
    vecs[2] = '{32'h0000_0043, 1'b0, 32'h0,         32'hDEAD_BEEF, 1'b0, 2};
    vecs[3] = '{32'h0000_0000, 1'b1, 32'h1111_1111, 32'h1111_1111, 1'b0, 0};
    vecs[4] = '{32'h0000_0044, 1'b1, 32'h0BAD_F00D, 32'h0BAD_F00D, 1'b0, 1};
    vecs[5] = '{32'h0000_0040, 1'b0, 32'h0,         32'hDEAD_BEEF, 1'b0, 0};
    vecs[6] = '{32'h0000_0044, 1'b0, 32'h0,         32'h0BAD_F00D, 1'b0, 10};
`ifdef BLOCK_MEMORY_RESP_ERR_EN
    vecs[7] = '{32'h0000_1000, 1'b1, 32'h0000_0001, 32'h0,         1'b1, 0};
    vecs[8] = '{32'h0000_0000, 1'b0, 32'h0,         32'h1111_1111, 1'b0, 0};
`else
    vecs[7] = '{32'h0000_1000, 1'b1, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 1'b0, 0};
    vecs[8] = '{32'h0000_0000, 1'b0, 32'h0,         32'hA5A5_A5A5, 1'b0, 0};
`endif
    vecs[9] = '{32'h0000_0FFC, 1'b1, 32'h7777_0001, 32'h7777_0001, 1'b0, 3};

    repeat (3) @(posedge clk);
    #1;
    check("reset req_ready", {31'd0, req_ready}, 32'd1);
    check("reset resp_valid", {31'd0, resp_valid}, 32'd0);
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset resp_rdata", resp_rdata, 32'd0);
    check("reset1 req_ready", {31'd0, req_ready_1}, 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++) begin
      run_txn(vecs[i], $sformatf("vec%0d", i));
    end

    // Reset two cycles after accepting a write: no response, write kept.
    req_addr = 32'h80; req_write = 1'b1; req_wdata = 32'h1234_5678; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("abort req_ready", {31'd0, req_ready}, 32'd1);
    check("abort resp_valid", {31'd0, resp_valid}, 32'd0);
    check("abort busy", {31'd0, busy}, 32'd0);
    check("abort resp_rdata", resp_rdata, 32'd0);
    rst = 1'b1;
    quiet = 1'b1;
    repeat (6) begin
      @(posedge clk); #1;
      if (resp_valid || busy) quiet = 1'b0;
    end
    check("abort no_response", {31'd0, quiet}, 32'd1);
    run_txn('{32'h80, 1'b0, 32'h0, 32'h1234_5678, 1'b0, 0}, "abort_readback");

    // LATENCY=1 instance: response in the cycle right after acceptance.
    run_txn1(32'h8, 1'b1, 32'hCAFE_F00D, 32'hCAFE_F00D, "lat1 write");
    run_txn1(32'h8, 1'b0, 32'h0,         32'hCAFE_F00D, "lat1 read");
    run_txn1(32'hC, 1'b1, 32'h0000_00FF, 32'h0000_00FF, "lat1 write2");
    run_txn1(32'h8, 1'b0, 32'h0,         32'hCAFE_F00D, "lat1 read_again");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, %0d/%0d", pass_cnt, total_cnt);
    $fatal(1);
  end

endmodule

`default_nettype wire

// File: doc/block_memory_responder.md
# block_memory_responder

Backing-memory responder on the memory side of the two-way LRU cache: accepts one word-block read or write request at a time over a valid/ready handshake and returns a response after a fixed, parameterised latency. It is the slave end of the cache refill/write-through path and doubles as the main-memory model in cache-level simulation. Storage is an internal synchronous array of `MEM_DEPTH` blocks.

## Interface
- `ADDR_SIZE`, 32, request address width in bits
- `BLOCK_SIZE`, 32, data block width in bits; must be a multiple of 8
- `MEM_DEPTH`, 1024, number of blocks stored; power of two
- `LATENCY`, 4, cycles from request acceptance to `resp_valid`; must be ≥1
- `clk` in 1: single clock, all logic on the rising edge
- `rst` in 1: synchronous, active-low reset (asserted when 0)
- `req_valid` in 1: request present
- `req_ready` out 1: responder can accept a request
- `req_addr` in `ADDR_SIZE`: byte address of the block
- `req_write` in 1: 1 = write, 0 = read
- `req_wdata` in `BLOCK_SIZE`: write data
- `resp_valid` out 1: response present
- `resp_ready` in 1: requester accepts response
- `resp_rdata` out `BLOCK_SIZE`: read data, or echoed write data for writes
- `busy` out 1: high whenever the FSM is not IDLE

## Operation
- Word index: `req_addr[OFS +: IDX]`, where OFS = $clog2(BLOCK_SIZE/8) and IDX = $clog2(MEM_DEPTH). The low OFS bits are ignored. Bits above OFS+IDX are ignored, so addresses wrap modulo MEM_DEPTH blocks.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: `req_ready`=1. On `req_valid`: latch addr, write flag, and data. A write commits to the array in this same cycle. Next state is WAIT if LATENCY>1, otherwise RESP.
  - WAIT: a counter of width $clog2(LATENCY+1) counts up to LATENCY-1 cycles, then the FSM moves to RESP. `req_ready`=0.
  - RESP: `resp_valid`=1. `resp_rdata` is stable and holds the array content at the latched index, or the latched write data for a write. On `resp_ready`=1 the FSM returns to IDLE.
- Only one request is outstanding at a time. There is no pipelining.
- A read issued after a write to the same index returns the new data.
- Array contents are not reset. They are undefined until written.

## Timing
- Reset (`rst`=0 at an edge): FSM goes to IDLE and the counter clears. `req_ready`=1, `resp_valid`=0, `resp_rdata`=0, `busy`=0 (and `resp_err`=0 when the Configuration macro is defined).
- Reset mid-WAIT or mid-RESP aborts the transaction and no response is produced. A write already committed at acceptance is not undone.
- A request accepted at edge T produces `resp_valid`=1 from cycle T+LATENCY.
- `resp_valid` is held with unchanged data for as long as `resp_ready` stays 0.
- If the response handshake completes at edge R, `req_ready`=1 in the cycle after R. The earliest next acceptance is at edge R+1.
- `req_valid` while `req_ready`=0 is ignored. The requester must hold the request until it is accepted.
- `resp_ready` outside RESP has no effect.

## Configuration
- `BLOCK_MEMORY_RESP_ERR_EN` defined:
  - Adds output port `resp_err` (1 bit). It is valid with `resp_valid` and 0 otherwise.
  - A request whose address bits above OFS+IDX are non-zero is flagged out of range. It responds with `resp_err`=1 and `resp_rdata`=0, and a write is not committed.
- Undefined: the port is absent and out-of-range addresses wrap silently as described in Operation.

## Test plan
- Write 0xDEADBEEF to 0x40, then read 0x40 → write response echoes 0xDEADBEEF at T+4; read returns 0xDEADBEEF at T'+4.
- Read with `resp_ready` held low 10 cycles → `resp_valid` stays 1 with constant data; after `resp_ready`=1, `req_ready` returns one cycle later.
- LATENCY=1: read request accepted at edge T → `resp_valid`=1 in cycle T+1; WAIT is never entered.
- Assert `rst`=0 two cycles after accepting a write of 0x12345678 to 0x80 → no response, outputs at reset values; a subsequent read of 0x80 returns 0x12345678.
- Without the macro and MEM_DEPTH=1024: write 0xA5A5A5A5 to 0x1000, then read 0x0 → returns 0xA5A5A5A5 (wrap-around).
- With `BLOCK_MEMORY_RESP_ERR_EN`: write 0x1 to 0x1000 → `resp_err`=1 and `resp_rdata`=0; a following read of 0x0 returns its previous contents.
